// File: rtl/tmr_pkg.sv
// Shared encodings for the TMR fault monitor: channel and clear-handshake states, channel indices.
// Pure declarations; no latency or backpressure of its own.
package tmr_pkg;

  typedef enum logic [1:0] {
    HEALTHY = 2'd0,
    SUSPECT = 2'd1,
    FAULTY  = 2'd2
  } ch_state_e;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } clr_state_e;

  localparam int CH_A = 0;
  localparam int CH_B = 1;
  localparam int CH_C = 2;

  function automatic logic two_or_more(input logic [2:0] f);
    return (f[0] & f[1]) | (f[1] & f[2]) | (f[0] & f[2]);
  endfunction

endpackage

// File: rtl/tmr_channel_fsm.sv
// One replica's HEALTHY/SUSPECT/FAULTY tracker with a consecutive-mismatch run counter.
// 1-cycle latency from sample to flags; never stalls, clear overrides any sample.
module tmr_channel_fsm
  import tmr_pkg::*;
#(
  parameter int MISMATCH_LIMIT = 4,
  parameter int RUN_W          = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic smp_vld_i,
  input  logic mis_i,
  input  logic clr_i,
  output logic suspect_o,
  output logic fault_o,
  output logic fault_nxt_o
);

  localparam logic [RUN_W-1:0] LIMIT = RUN_W'(MISMATCH_LIMIT);
  localparam logic [RUN_W-1:0] ONE   = {{(RUN_W-1){1'b0}}, 1'b1};

  ch_state_e        state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [RUN_W-1:0] run_inc;

  assign run_inc = run_q + ONE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= HEALTHY;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    if (clr_i) begin
      state_d = HEALTHY;
      run_d   = '0;
    end else if (mis_i) begin
      case (state_q)
        HEALTHY: begin
          run_d   = ONE;
          state_d = (LIMIT == ONE) ? FAULTY : SUSPECT;
        end
        SUSPECT: begin
          run_d = run_inc;
          if (run_inc == LIMIT) state_d = FAULTY;
        end
        default: ;
      endcase
    end else if (smp_vld_i && state_q == SUSPECT) begin
      // A single matching sample breaks the run.
      state_d = HEALTHY;
      run_d   = '0;
    end
  end

  assign suspect_o   = (state_q == SUSPECT);
  assign fault_o     = (state_q == FAULTY);
  assign fault_nxt_o = (state_d == FAULTY);

endmodule

// File: rtl/tmr_fault_monitor.sv
// Per-channel disagreement monitor behind a TMR voter; all outputs registered, 1-cycle latency, never stalls.
// Optional TMR_VOTER_CHECK_EN adds a sticky voter_err that rejects samples whose voted bit is not the majority.
module tmr_fault_monitor
  import tmr_pkg::*;
#(
  parameter int MISMATCH_LIMIT = 4,
  parameter int RUN_W          = 4,
  parameter int ERR_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             voted,
  input  logic             clr_req,
  output logic             clr_ack,
  output logic [2:0]       fault,
  output logic [2:0]       suspect,
  output logic             sys_fail,
  output logic [ERR_W-1:0] err_count
`ifdef TMR_VOTER_CHECK_EN
  ,
  output logic             voter_err
`endif
);

  clr_state_e       clr_state_q, clr_state_d;
  logic             clr_fire;
  logic             smp_vld;
  logic [2:0]       ch;
  logic [2:0]       mis;
  logic [2:0]       fault_nxt;
  logic             sys_fail_q;
  logic [ERR_W-1:0] err_q, err_d;

  assign ch       = {c, b, a};
  assign clr_fire = (clr_state_q == IDLE) && clr_req;

`ifdef TMR_VOTER_CHECK_EN
  logic maj, voter_bad, voter_err_q, voter_err_d;
  assign maj         = (a & b) | (b & c) | (a & c);
  assign voter_bad   = in_valid && (voted != maj);
  assign voter_err_d = clr_fire ? 1'b0 : (voter_err_q | voter_bad);
  assign smp_vld     = in_valid && !clr_fire && !voter_bad;
  assign voter_err   = voter_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) voter_err_q <= 1'b0;
    else        voter_err_q <= voter_err_d;
  end
`else
  assign smp_vld = in_valid && !clr_fire;
`endif

  assign mis = {3{smp_vld}} & (ch ^ {3{voted}});

  always_comb begin
    clr_state_d = clr_state_q;
    case (clr_state_q)
      IDLE:    if (clr_req)  clr_state_d = ACK;
      ACK:     if (!clr_req) clr_state_d = IDLE;
      default: clr_state_d = IDLE;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (clr_fire)                            err_d = '0;
    else if (|mis && err_q != {ERR_W{1'b1}}) err_d = err_q + {{(ERR_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clr_state_q <= IDLE;
      err_q       <= '0;
      sys_fail_q  <= 1'b0;
    end else begin
      clr_state_q <= clr_state_d;
      err_q       <= err_d;
      sys_fail_q  <= two_or_more(fault_nxt);
    end
  end

  tmr_channel_fsm #(.MISMATCH_LIMIT(MISMATCH_LIMIT), .RUN_W(RUN_W)) u_ch_a (
    .clk(clk), .rst_n(rst_n), .smp_vld_i(smp_vld), .mis_i(mis[CH_A]), .clr_i(clr_fire),
    .suspect_o(suspect[CH_A]), .fault_o(fault[CH_A]), .fault_nxt_o(fault_nxt[CH_A])
  );

  tmr_channel_fsm #(.MISMATCH_LIMIT(MISMATCH_LIMIT), .RUN_W(RUN_W)) u_ch_b (
    .clk(clk), .rst_n(rst_n), .smp_vld_i(smp_vld), .mis_i(mis[CH_B]), .clr_i(clr_fire),
    .suspect_o(suspect[CH_B]), .fault_o(fault[CH_B]), .fault_nxt_o(fault_nxt[CH_B])
  );

  tmr_channel_fsm #(.MISMATCH_LIMIT(MISMATCH_LIMIT), .RUN_W(RUN_W)) u_ch_c (
    .clk(clk), .rst_n(rst_n), .smp_vld_i(smp_vld), .mis_i(mis[CH_C]), .clr_i(clr_fire),
    .suspect_o(suspect[CH_C]), .fault_o(fault[CH_C]), .fault_nxt_o(fault_nxt[CH_C])
  );

  assign clr_ack   = (clr_state_q == ACK);
  assign sys_fail  = sys_fail_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// Bench for tmr_fault_monitor: run-length reference model checked every cycle, plus directed literal checkpoints.
// Two instances share stimulus; the second uses a 2-bit error counter to exercise saturation.
module tb_tmr_fault_monitor;

  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, a = 1'b0, b = 1'b0, c = 1'b0, voted = 1'b0, clr_req = 1'b0;

  logic       ack1, ack2, sf1, sf2;
  logic [2:0] f1, f2, s1, s2;
  logic [7:0] err1;
  logic [1:0] err2;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

`ifdef TMR_VOTER_CHECK_EN
  logic verr1, verr2;
`endif

  tmr_fault_monitor #(.MISMATCH_LIMIT(LIM), .RUN_W(4), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .c(c), .voted(voted),
    .clr_req(clr_req), .clr_ack(ack1), .fault(f1), .suspect(s1), .sys_fail(sf1), .err_count(err1)
`ifdef TMR_VOTER_CHECK_EN
    , .voter_err(verr1)
`endif
  );

  tmr_fault_monitor #(.MISMATCH_LIMIT(LIM), .RUN_W(4), .ERR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .c(c), .voted(voted),
    .clr_req(clr_req), .clr_ack(ack2), .fault(f2), .suspect(s2), .sys_fail(sf2), .err_count(err2)
`ifdef TMR_VOTER_CHECK_EN
    , .voter_err(verr2)
`endif
  );

  // Reference model: runs of mismatches per channel, sticky fault bits, plain integer counters.
  int         m_run [3];
  logic [2:0] m_flt;
  int         m_err1, m_err2;
  logic       m_ack, m_sysf, m_verr;

  function automatic logic [2:0] m_susp();
    logic [2:0] s;
    for (int i = 0; i < 3; i++) s[i] = !m_flt[i] && (m_run[i] > 0);
    return s;
  endfunction

  always @(posedge clk) begin
    logic fire, ack_n, any, vbad, chv;
    int nf;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) m_run[i] = 0;
      m_flt = 3'b000; m_err1 = 0; m_err2 = 0; m_ack = 1'b0; m_sysf = 1'b0; m_verr = 1'b0;
    end else begin
      fire  = !m_ack && clr_req;
      ack_n = fire || (m_ack && clr_req);
`ifdef TMR_VOTER_CHECK_EN
      vbad = in_valid && (voted != ((a & b) | (b & c) | (a & c)));
`else
      vbad = 1'b0;
`endif
      if (fire) begin
        for (int i = 0; i < 3; i++) m_run[i] = 0;
        m_flt = 3'b000; m_err1 = 0; m_err2 = 0; m_verr = 1'b0;
      end else begin
        if (vbad) m_verr = 1'b1;
        if (in_valid && !vbad) begin
          any = 1'b0;
          for (int i = 0; i < 3; i++) begin
            chv = (i == 0) ? a : (i == 1) ? b : c;
            if (chv != voted) begin
              any = 1'b1;
              if (!m_flt[i]) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] >= LIM) m_flt[i] = 1'b1;
              end
            end else if (!m_flt[i]) begin
              m_run[i] = 0;
            end
          end
          if (any) begin
            if (m_err1 < 255) m_err1 = m_err1 + 1;
            if (m_err2 < 3)   m_err2 = m_err2 + 1;
          end
        end
      end
      m_ack = ack_n;
      nf = int'(m_flt[0]) + int'(m_flt[1]) + int'(m_flt[2]);
      m_sysf = (nf >= 2);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Every-cycle comparison against the model, after the DUT has settled.
  always @(posedge clk) begin
    #2;
    chk("cyc_fault",   int'(f1),   int'(m_flt));
    chk("cyc_suspect", int'(s1),   int'(m_susp()));
    chk("cyc_sysfail", int'(sf1),  int'(m_sysf));
    chk("cyc_err",     int'(err1), m_err1);
    chk("cyc_ack",     int'(ack1), int'(m_ack));
    chk("cyc2_fault",  int'(f2),   int'(m_flt));
    chk("cyc2_err",    int'(err2), m_err2);
    chk("cyc2_ack",    int'(ack2), int'(m_ack));
`ifdef TMR_VOTER_CHECK_EN
    chk("cyc_verr",    int'(verr1), int'(m_verr));
`endif
  end

  task automatic tick(input logic r, input logic v, input logic ia, input logic ib,
                      input logic ic, input logic ivo, input logic icr);
    @(negedge clk);
    rst_n = r; in_valid = v; a = ia; b = ib; c = ic; voted = ivo; clr_req = icr;
    @(posedge clk);
    #3;
  endtask

  task automatic expect_out(input string nm, input logic [2:0] ef, input logic [2:0] es,
                            input logic esf, input int eerr, input logic eack);
    chk({nm, "_fault"},   int'(f1),    int'(ef));
    chk({nm, "_suspect"}, int'(s1),    int'(es));
    chk({nm, "_sysfail"}, int'(sf1),   int'(esf));
    chk({nm, "_err"},     int'(err1),  eerr);
    chk({nm, "_ack"},     int'(ack1),  int'(eack));
    chk({nm, "_model"},   int'(m_flt), int'(ef));
  endtask

  initial begin
    // Reset with random inputs.
    for (int i = 0; i < 2; i++)
      tick(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    expect_out("reset", 3'b000, 3'b000, 1'b0, 0, 1'b0);
    chk("reset_err2", int'(err2), 0);

    // Single faulty channel a.
    for (int i = 1; i <= 3; i++) begin
      tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_out("single_susp", 3'b000, 3'b001, 1'b0, i, 1'b0);
    end
    tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("single_fault", 3'b001, 3'b000, 1'b0, 4, 1'b0);
    chk("single_err2_sat", int'(err2), 3);

    // Clear coincident with a mismatching sample: sample discarded.
    tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_out("clr_fire", 3'b000, 3'b000, 1'b0, 0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_out("clr_hold", 3'b000, 3'b000, 1'b0, 0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("clr_drop", 3'b000, 3'b000, 1'b0, 0, 1'b0);

    // Intermittent mismatches never reach the limit.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("inter_run3", 3'b000, 3'b001, 1'b0, 3, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("inter_match", 3'b000, 3'b000, 1'b0, 3, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("inter_end", 3'b000, 3'b001, 1'b0, 6, 1'b0);
    chk("inter_err2_sat", int'(err2), 3);

    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("clr2", 3'b000, 3'b000, 1'b0, 0, 1'b0);

    // Double fault: a then b.
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("dbl_a", 3'b001, 3'b000, 1'b0, 4, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("dbl_b3", 3'b001, 3'b010, 1'b0, 7, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("dbl_sysfail", 3'b011, 3'b000, 1'b1, 8, 1'b0);

    // Invalid samples with mismatching data change nothing.
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_out("gate", 3'b011, 3'b000, 1'b1, 8, 1'b0);

    // Clear drops sys_fail.
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    expect_out("clr_sys", 3'b000, 3'b000, 1'b0, 0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("clr_sys_drop", 3'b000, 3'b000, 1'b0, 0, 1'b0);

    // Reset mid-handshake, request still high afterwards is a new clear.
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_out("rst_hs_ack", 3'b000, 3'b000, 1'b0, 0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_out("rst_hs_rst", 3'b000, 3'b000, 1'b0, 0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    expect_out("rst_hs_new", 3'b000, 3'b000, 1'b0, 0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("rst_hs_drop", 3'b000, 3'b000, 1'b0, 0, 1'b0);

    // Counting resumes normally after the handshake.
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("rearm_c", 3'b000, 3'b100, 1'b0, 1, 1'b0);

    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
